// File: rtl/btb_update_ctrl_pkg.sv
// Shared types and constants for the BTB/BHT write-side controller.
// Holds FSM encoding, FIFO entry layout and the sweep tag fill.
package btb_update_ctrl_pkg;

    localparam int WORD_SIZE      = 16;
    localparam int DEF_BTB_SIZE   = 256;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [WORD_SIZE-1:0] pc;
        logic [WORD_SIZE-1:0] target;
        logic                 taken;
        logic                 mispredict;
    } upd_entry_t;

    localparam logic [WORD_SIZE-1:0] TAG_FILL = '1;

endpackage

// File: rtl/btb_update_ctrl_if.sv
// Resolution-update requests in, predictor write strobes out.
// master = requesters/predictor side, slave = controller.
interface btb_update_ctrl_if;
    import btb_update_ctrl_pkg::*;

    logic                 ex_upd_valid;
    logic [WORD_SIZE-1:0] ex_upd_pc;
    logic [WORD_SIZE-1:0] ex_upd_target;
    logic                 ex_upd_taken;
    logic                 ex_upd_mispredict;
    logic                 id_upd_valid;
    logic [WORD_SIZE-1:0] id_upd_pc;
    logic [WORD_SIZE-1:0] id_upd_target;
    logic                 id_upd_mispredict;
    logic                 upd_stall;
    logic                 init_busy;
    logic                 btb_write;
    logic                 bht_update;
    logic                 bht_flush;
    logic [WORD_SIZE-1:0] write_pc;
    logic [WORD_SIZE-1:0] pc_target;

    modport master (
        output ex_upd_valid, ex_upd_pc, ex_upd_target,
        output ex_upd_taken, ex_upd_mispredict,
        output id_upd_valid, id_upd_pc, id_upd_target,
        output id_upd_mispredict,
        input  upd_stall, init_busy, btb_write,
        input  bht_update, bht_flush, write_pc, pc_target
    );

    modport slave (
        input  ex_upd_valid, ex_upd_pc, ex_upd_target,
        input  ex_upd_taken, ex_upd_mispredict,
        input  id_upd_valid, id_upd_pc, id_upd_target,
        input  id_upd_mispredict,
        output upd_stall, init_busy, btb_write,
        output bht_update, bht_flush, write_pc, pc_target
    );

endinterface

// File: rtl/btb_update_ctrl_upd_fifo.sv
// Dual-push / single-pop pending-update FIFO.
// Port a is written ahead of port b when both push.
module upd_fifo
    import btb_update_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push_a,
    input  upd_entry_t    i_din_a,
    input  logic          push_b,
    input  upd_entry_t    i_din_b,
    input  logic          pop,
    output upd_entry_t    o_dout,
    output logic [CW-1:0] count
);

    upd_entry_t        r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     w_wr_ptr1;
    logic [PW-1:0]     w_b_ptr;

    assign w_wr_ptr1 = r_wr_ptr + PW'(1);
    assign w_b_ptr   = push_a ? w_wr_ptr1 : r_wr_ptr;
    assign o_dout    = r_mem[r_rd_ptr];
    assign count     = r_count;

    // storage: b lands behind a when both push
    always_ff @(posedge clk) begin
        if (push_a) r_mem[r_wr_ptr] <= i_din_a;
        if (push_b) r_mem[w_b_ptr]  <= i_din_b;
    end

    // pointers and occupancy, wrapping modulo depth
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(push_a) + PW'(push_b);
            r_rd_ptr <= r_rd_ptr + PW'(pop);
            r_count  <= r_count + CW'(push_a) + CW'(push_b)
                        - CW'(pop);
        end
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB/BHT write controller: init sweep, then queued EX/ID updates.
// Optional BTB_UPD_PERF_CNT_EN adds predict_cnt / flush_cnt outputs.
module btb_update_ctrl
    import btb_update_ctrl_pkg::*;
#(
    parameter int BTB_SIZE   = DEF_BTB_SIZE,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    btb_update_ctrl_if.slave     bus
`ifdef BTB_UPD_PERF_CNT_EN
    ,
    output logic [WORD_SIZE-1:0] predict_cnt,
    output logic [WORD_SIZE-1:0] flush_cnt
`endif
);

    localparam int IDX_W = $clog2(BTB_SIZE);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    state_t               r_state;
    state_t               w_next_state;
    logic [IDX_W-1:0]     r_init_idx;
    logic                 r_btb_write;
    logic                 r_bht_update;
    logic                 r_bht_flush;
    logic                 r_init_busy;
    logic [WORD_SIZE-1:0] r_write_pc;
    logic [WORD_SIZE-1:0] r_pc_target;
    logic                 w_btb_write;
    logic                 w_bht_update;
    logic                 w_bht_flush;
    logic                 w_init_busy;
    logic [WORD_SIZE-1:0] w_write_pc;
    logic [WORD_SIZE-1:0] w_pc_target;
    logic                 w_stall;
    logic                 w_push_a;
    logic                 w_push_b;
    logic                 w_pop;
    logic [CW-1:0]        w_count;
    upd_entry_t           w_head;
    upd_entry_t           w_din_a;
    upd_entry_t           w_din_b;

    // keep two free slots whenever requests are accepted
    assign w_stall  = r_init_busy
                    | (w_count > CW'(FIFO_DEPTH - 2));
    assign w_push_a = !w_stall && (r_state == RUN)
                    && bus.ex_upd_valid;
    assign w_push_b = !w_stall && (r_state == RUN)
                    && bus.id_upd_valid;
    assign w_pop    = (r_state == RUN) && (w_count != '0);

    assign w_din_a = '{pc:         bus.ex_upd_pc,
                       target:     bus.ex_upd_target,
                       taken:      bus.ex_upd_taken,
                       mispredict: bus.ex_upd_mispredict};
    assign w_din_b = '{pc:         bus.id_upd_pc,
                       target:     bus.id_upd_target,
                       taken:      1'b1,
                       mispredict: bus.id_upd_mispredict};

    upd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_a  (w_push_a),
        .i_din_a (w_din_a),
        .push_b  (w_push_b),
        .i_din_b (w_din_b),
        .pop     (w_pop),
        .o_dout  (w_head),
        .count   (w_count)
    );

    // state register and sweep index
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= INIT;
            r_init_idx <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == INIT) r_init_idx <= r_init_idx + IDX_W'(1);
        end
    end

    // leave the sweep once the last index has been issued
    always_comb begin
        w_next_state = r_state;
        if (r_state == INIT && r_init_idx == '1) w_next_state = RUN;
    end

    // next values of the registered write-port strobes
    always_comb begin
        w_btb_write  = 1'b0;
        w_bht_update = 1'b0;
        w_bht_flush  = 1'b0;
        w_write_pc   = r_write_pc;
        w_pc_target  = r_pc_target;
        w_init_busy  = (r_state == INIT);
        unique case (r_state)
            INIT: begin
                w_btb_write            = 1'b1;
                w_write_pc             = TAG_FILL;
                w_write_pc[IDX_W-1:0]  = r_init_idx;
                w_pc_target            = '0;
            end
            RUN: begin
                if (w_pop) begin
                    w_bht_update = 1'b1;
                    w_bht_flush  = w_head.mispredict;
                    w_btb_write  = w_head.taken;
                    w_write_pc   = w_head.pc;
                    w_pc_target  = w_head.target;
                end
            end
        endcase
    end

    // output registers; busy lags state to align with the strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_btb_write  <= 1'b0;
            r_bht_update <= 1'b0;
            r_bht_flush  <= 1'b0;
            r_write_pc   <= '0;
            r_pc_target  <= '0;
            r_init_busy  <= 1'b1;
        end else begin
            r_btb_write  <= w_btb_write;
            r_bht_update <= w_bht_update;
            r_bht_flush  <= w_bht_flush;
            r_write_pc   <= w_write_pc;
            r_pc_target  <= w_pc_target;
            r_init_busy  <= w_init_busy;
        end
    end

    assign bus.upd_stall  = w_stall;
    assign bus.init_busy  = r_init_busy;
    assign bus.btb_write  = r_btb_write;
    assign bus.bht_update = r_bht_update;
    assign bus.bht_flush  = r_bht_flush;
    assign bus.write_pc   = r_write_pc;
    assign bus.pc_target  = r_pc_target;

`ifdef BTB_UPD_PERF_CNT_EN
    // count issued updates and flush-direction steps
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            predict_cnt <= '0;
            flush_cnt   <= '0;
        end else begin
            if (w_bht_update) predict_cnt <= predict_cnt + WORD_SIZE'(1);
            if (w_bht_flush)  flush_cnt   <= flush_cnt + WORD_SIZE'(1);
        end
    end
`endif

endmodule
